// File: rtl/duck_pkg.sv
// Shared types and constants for the duck sprite engine: FSM states, LFSR seed/taps
// and default sprite dimensions.
package duck_pkg;

  typedef enum logic [2:0] {
    RESPAWN,
    FLYING,
    HIT,
    FALLING,
    ESCAPING,
    GAME_OVER
  } duck_state_t;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam int         DEF_DUCK_W = 80;
  localparam int         DEF_DUCK_H = 72;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/duck_controller_pulse_sync.sv
// Two-flop synchroniser plus rising-edge detector; one-cycle pulse appears two Clk
// edges after the input rises and is consumed on the third. No backpressure.
module pulse_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic sig_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], sig_i};
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/duck_controller.sv
// Per-frame duck motion / game-state engine; state, lives and score update on the Clk
// edge that consumes frame_tick (3 Clk after frame_clk rises). Pixel outputs are combinational; no backpressure.
module duck_controller
  import duck_pkg::*;
#(
  parameter int DUCK_W        = DEF_DUCK_W,
  parameter int DUCK_H        = DEF_DUCK_H,
  parameter int SCREEN_W      = 640,
  parameter int GROUND_Y      = 360,
  parameter int SPEED_X       = 2,
  parameter int SPEED_Y       = 2,
  parameter int FALL_SPEED    = 4,
  parameter int HIT_FRAMES    = 30,
  parameter int ESCAPE_FRAMES = 300,
  parameter int START_LIVES   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       trigger,
  input  logic [9:0] Ball_X,
  input  logic [9:0] Ball_Y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_duck,
  output logic [9:0] Duck_Draw_X,
  output logic [9:0] Duck_Draw_Y,
  output logic [3:0] lives,
  output logic [7:0] score,
  output logic       game_over
);

  localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - DUCK_W);
  localparam logic signed [11:0] Y_GND  = 12'(GROUND_Y - DUCK_H);
  localparam logic signed [11:0] W_S    = 12'(DUCK_W);
  localparam logic signed [11:0] H_S    = 12'(DUCK_H);
  localparam logic signed [11:0] SPX_S  = 12'(SPEED_X);
  localparam logic signed [11:0] SPY_S  = 12'(SPEED_Y);
  localparam logic signed [11:0] ESC_S  = 12'(2 * SPEED_Y);
  localparam logic signed [11:0] FALL_S = 12'(FALL_SPEED);
  localparam logic [9:0]         W_M1   = 10'(DUCK_W - 1);

  logic frame_tick, shot;

  pulse_sync u_frame_sync (.Clk(Clk), .Reset(Reset), .sig_i(frame_clk), .pulse_o(frame_tick));
  pulse_sync u_trig_sync  (.Clk(Clk), .Reset(Reset), .sig_i(trigger),   .pulse_o(shot));

  duck_state_t       state_q;
  logic signed [10:0] duck_x_q, duck_y_q;
  logic              dir_q;
  logic [8:0]        frame_cnt_q;
  logic [7:0]        lfsr_q;
  logic [3:0]        lives_q;
  logic [7:0]        score_q;
  logic              game_over_q;

  logic signed [11:0] x_ext, y_ext, x_step, y_step, fall_y, esc_y, bx, by, dx, dy;
  logic signed [10:0] fly_x_d, fly_y_d, fall_y_d, esc_y_d, spawn_x_d;
  logic               fly_dir_d, land, gone, hit, in_box;

  assign x_ext = {duck_x_q[10], duck_x_q};
  assign y_ext = {duck_y_q[10], duck_y_q};

  always_comb begin
    x_step    = dir_q ? x_ext + SPX_S : x_ext - SPX_S;
    fly_x_d   = x_step[10:0];
    fly_dir_d = dir_q;
    if (x_step > X_MAX) begin
      fly_x_d   = X_MAX[10:0];
      fly_dir_d = 1'b0;
    end else if (x_step < 12'sd0) begin
      fly_x_d   = '0;
      fly_dir_d = 1'b1;
    end
    y_step    = y_ext - SPY_S;
    fly_y_d   = (y_step < 12'sd0) ? 11'sd0 : y_step[10:0];
    fall_y    = y_ext + FALL_S;
    land      = fall_y >= Y_GND;
    fall_y_d  = land ? Y_GND[10:0] : fall_y[10:0];
    esc_y     = y_ext - ESC_S;
    esc_y_d   = esc_y[10:0];
    gone      = (esc_y + H_S) <= 12'sd0;
    spawn_x_d = {2'b00, lfsr_q, 1'b0} % 11'(SCREEN_W - DUCK_W);
    // Scope coordinates are unsigned; widening keeps off-screen (negative) duck edges comparable.
    bx        = $signed({2'b00, Ball_X});
    by        = $signed({2'b00, Ball_Y});
    hit       = (bx >= x_ext) && (bx < x_ext + W_S) && (by >= y_ext) && (by < y_ext + H_S);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RESPAWN;
      duck_x_q    <= '0;
      duck_y_q    <= Y_GND[10:0];
      dir_q       <= 1'b1;
      frame_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      lives_q     <= 4'(START_LIVES);
      score_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      case (state_q)
        RESPAWN: if (frame_tick) begin
          duck_x_q    <= spawn_x_d;
          duck_y_q    <= Y_GND[10:0];
          dir_q       <= lfsr_q[0];
          frame_cnt_q <= '0;
          state_q     <= FLYING;
        end
        FLYING: begin
          // A shot landing in the same cycle as a tick freezes the duck where it was hit.
          if (shot && hit) begin
            frame_cnt_q <= '0;
            state_q     <= HIT;
          end else if (frame_tick) begin
            duck_x_q    <= fly_x_d;
            duck_y_q    <= fly_y_d;
            dir_q       <= fly_dir_d;
            frame_cnt_q <= frame_cnt_q + 9'd1;
            if (frame_cnt_q + 9'd1 == 9'(ESCAPE_FRAMES)) state_q <= ESCAPING;
          end
        end
        HIT: if (frame_tick) begin
          if (frame_cnt_q == 9'(HIT_FRAMES - 1)) begin
            frame_cnt_q <= '0;
            state_q     <= FALLING;
          end else begin
            frame_cnt_q <= frame_cnt_q + 9'd1;
          end
        end
        FALLING: if (frame_tick) begin
          duck_y_q <= fall_y_d;
          if (land) begin
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
            state_q <= RESPAWN;
          end
        end
        ESCAPING: if (frame_tick) begin
          duck_y_q <= esc_y_d;
          if (gone) begin
            lives_q <= lives_q - 4'd1;
            if (lives_q == 4'd1) begin
              game_over_q <= 1'b1;
              state_q     <= GAME_OVER;
            end else begin
              state_q <= RESPAWN;
            end
          end
        end
        GAME_OVER: game_over_q <= 1'b1;
        default:   state_q <= RESPAWN;
      endcase
    end
  end

  always_comb begin
    dx          = $signed({2'b00, DrawX}) - x_ext;
    dy          = $signed({2'b00, DrawY}) - y_ext;
    in_box      = (dx >= 12'sd0) && (dx < W_S) && (dy >= 12'sd0) && (dy < H_S) &&
                  (state_q != GAME_OVER);
    is_duck     = in_box;
    Duck_Draw_X = '0;
    Duck_Draw_Y = '0;
    if (in_box) begin
      Duck_Draw_X = dir_q ? dx[9:0] : W_M1 - dx[9:0];
      Duck_Draw_Y = dy[9:0];
    end
  end

  assign lives     = lives_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_duck_controller.sv
// Directed bench for duck_controller: spawn, edge clamp, hit/fall, misses, pixel mapping,
// escapes to game over and reset mid-fall, against hand-computed values and a small motion model.
module tb_duck_controller;
  import duck_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       trigger = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0, draw_x = '0, draw_y = '0;
  logic       is_duck, game_over;
  logic [9:0] duck_draw_x, duck_draw_y;
  logic [3:0] lives;
  logic [7:0] score;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_lfsr;
  logic [7:0] last_l;
  int         mx, my, mdir;

  duck_controller dut (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .trigger(trigger),
    .Ball_X(ball_x), .Ball_Y(ball_y), .DrawX(draw_x), .DrawY(draw_y),
    .is_duck(is_duck), .Duck_Draw_X(duck_draw_x), .Duck_Draw_Y(duck_draw_y),
    .lives(lives), .score(score), .game_over(game_over)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= nxt(m_lfsr);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int st();
    return int'(dut.state_q);
  endfunction
  function automatic int xq();
    return int'(dut.duck_x_q);
  endfunction
  function automatic int yq();
    return int'(dut.duck_y_q);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_clk = 1'b0; trigger = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise frame_clk and/or trigger; the pulse is consumed on the third posedge.
  task automatic pulse(input bit tk, input bit sh);
    frame_clk = tk; trigger = sh;
    @(negedge clk);
    @(negedge clk);
    last_l = m_lfsr;
    @(negedge clk);
    frame_clk = 1'b0; trigger = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse(1'b1, 1'b0);
  endtask

  task automatic shoot(input int bxv, input int byv);
    ball_x = 10'(bxv); ball_y = 10'(byv);
    pulse(1'b0, 1'b1);
  endtask

  task automatic model_fly();
    if (mdir != 0) begin
      mx += 2;
      if (mx > 560) begin mx = 560; mdir = 0; end
    end else begin
      mx -= 2;
      if (mx < 0) begin mx = 0; mdir = 1; end
    end
    my = (my - 2 < 0) ? 0 : my - 2;
  endtask

  task automatic fly(input int n);
    repeat (n) begin
      pulse(1'b1, 1'b0);
      model_fly();
    end
  endtask

  // Delay the tick until the LFSR value it will consume equals target.
  task automatic spawn_at(input logic [7:0] target);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (nxt(nxt(m_lfsr)) == target) found = 1'b1;
      else @(negedge clk);
    end
    check("spawn_seek", int'(found), 1);
    pulse(1'b1, 1'b0);
    mx = 2 * int'(target); my = 288; mdir = int'(target[0]);
    check("spawn_x", xq(), mx);
    check("spawn_dir", int'(dut.dir_q), mdir);
  endtask

  task automatic probe(input int px, input int py, input int e_is, input int e_dx, input int e_dy);
    draw_x = 10'(px); draw_y = 10'(py);
    #1;
    check("pix_is_duck", int'(is_duck), e_is);
    check("pix_draw_x", int'(duck_draw_x), e_dx);
    check("pix_draw_y", int'(duck_draw_y), e_dy);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int vis;

    do_reset();
    check("rst_lives", int'(lives), 3);
    check("rst_score", int'(score), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_state", st(), int'(RESPAWN));
    check("rst_x", xq(), 0);
    check("rst_y", yq(), 288);
    check("rst_dir", int'(dut.dir_q), 1);
    probe(5, 300, 1, 5, 12);
    pulse(1'b1, 1'b0);
    check("first_state", st(), int'(FLYING));
    check("first_x", xq(), (2 * int'(last_l)) % 560);
    check("first_x_range", int'(xq() <= 560), 1);
    check("first_y", yq(), 288);
    check("first_dir", int'(dut.dir_q), int'(last_l[0]));
    check("first_lives", int'(lives), 3);

    // Right-edge clamp: spawn at 502 heading right.
    do_reset();
    spawn_at(8'd251);
    fly(29);
    check("edge_pre_x", xq(), 560);
    check("edge_pre_dir", int'(dut.dir_q), 1);
    check("edge_pre_y", yq(), 230);
    fly(1);
    check("edge_clamp_x", xq(), 560);
    check("edge_clamp_dir", int'(dut.dir_q), 0);
    check("edge_clamp_y", yq(), 228);
    fly(1);
    check("edge_back_x", xq(), 558);
    probe(558, 226, 1, 79, 0);

    // Hit at the inclusive corner of the box, freeze, fall, score.
    do_reset();
    spawn_at(8'd51);
    fly(44);
    check("hit_pre_x", xq(), 190);
    check("hit_pre_y", yq(), 200);
    shoot(269, 271);
    check("hit_state", st(), int'(HIT));
    ticks(29);
    check("hit_hold_state", st(), int'(HIT));
    check("hit_hold_x", xq(), 190);
    check("hit_hold_y", yq(), 200);
    ticks(1);
    check("fall_start_state", st(), int'(FALLING));
    check("fall_start_y", yq(), 200);
    ticks(21);
    check("fall_mid_y", yq(), 284);
    check("fall_mid_score", int'(score), 0);
    ticks(1);
    check("land_y", yq(), 288);
    check("land_state", st(), int'(RESPAWN));
    check("land_score", int'(score), 1);

    // Misses on the exclusive/inclusive bounds, pixel mapping, coincident shot+tick.
    spawn_at(8'd100);
    shoot(199, 300);
    check("miss_left_state", st(), int'(FLYING));
    shoot(280, 300);
    check("miss_right_state", st(), int'(FLYING));
    shoot(240, 360);
    check("miss_below_state", st(), int'(FLYING));
    check("miss_x", xq(), 200);
    probe(205, 298, 1, 74, 10);
    probe(280, 298, 0, 0, 0);
    probe(279, 359, 1, 0, 71);
    ball_x = 10'd240; ball_y = 10'd328;
    pulse(1'b1, 1'b1);
    check("coinc_state", st(), int'(HIT));
    check("coinc_x", xq(), 200);
    check("coinc_y", yq(), 288);
    ticks(30);
    check("coinc_fall_state", st(), int'(FALLING));
    ticks(1);
    check("coinc_land_state", st(), int'(RESPAWN));
    check("coinc_score", int'(score), 2);

    // Three escapes exhaust the lives.
    for (int e = 0; e < 3; e++) begin
      spawn_at(8'(40 + e));
      fly(299);
      check("esc_fly_state", st(), int'(FLYING));
      check("esc_fly_x", xq(), mx);
      check("esc_fly_y", yq(), my);
      fly(1);
      check("esc_state", st(), int'(ESCAPING));
      if (e == 0) begin
        shoot(mx + 40, 10);
        check("esc_shot_ignored", st(), int'(ESCAPING));
      end
      ticks(17);
      check("esc_mid_y", yq(), -68);
      check("esc_mid_lives", int'(lives), 3 - e);
      ticks(1);
      check("esc_gone_y", yq(), -72);
      check("esc_lives", int'(lives), 2 - e);
      check("esc_next_state", st(), (e < 2) ? int'(RESPAWN) : int'(GAME_OVER));
      check("esc_game_over", int'(game_over), (e < 2) ? 0 : 1);
    end
    vis = 0;
    for (int px = 0; px < 640; px += 37) begin
      for (int py = 0; py < 480; py += 29) begin
        draw_x = 10'(px); draw_y = 10'(py);
        #1;
        if (is_duck) vis++;
      end
    end
    check("gameover_no_pixels", vis, 0);
    ball_x = 10'(mx + 40); ball_y = 10'd10;
    pulse(1'b1, 1'b1);
    check("gameover_sticky_state", st(), int'(GAME_OVER));
    check("gameover_sticky_lives", int'(lives), 0);
    check("gameover_sticky_flag", int'(game_over), 1);

    // Reset in the middle of a fall.
    do_reset();
    spawn_at(8'd51);
    fly(10);
    shoot(162, 300);
    check("mf_hit_state", st(), int'(HIT));
    ticks(30);
    ticks(2);
    check("mf_fall_state", st(), int'(FALLING));
    check("mf_fall_y", yq(), 276);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mf_rst_state", st(), int'(RESPAWN));
    check("mf_rst_x", xq(), 0);
    check("mf_rst_y", yq(), 288);
    check("mf_rst_dir", int'(dut.dir_q), 1);
    check("mf_rst_lives", int'(lives), 3);
    check("mf_rst_score", int'(score), 0);
    check("mf_rst_game_over", int'(game_over), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
